// File: rtl/uart_rx.sv
// UART receiver: synchronised rx line, mid-bit sampling from a baud divider,
// one-cycle valid pulse carrying data plus parity and framing status.
module uart_rx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_user_rx_check_err,
  output logic                         o_user_rx_frame_err
);

  localparam int W    = P_UART_DATA_WIDTH;
  localparam int DIV  = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [3:0]    LAST_D  = 4'(W - 1);
  localparam logic [3:0]    LAST_S  = 4'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    CHECK,
    STOP
  } state_t;

  state_t state, state_n;

  logic          s1, s2, s3;
  logic          fall;
  logic          tick;
  logic          done;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [W-1:0]  shreg;
  logic          par_bit;
  logic          ferr_acc;
  logic          ones_odd;

  assign fall = s3 & ~s2;
  assign tick = (state == START) ? (cnt == HALF_M1) : (cnt == DIV_M1);
  assign ones_odd = ^{shreg, par_bit};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= i_uart_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  // valid cycle blocks re-arm so a new frame starts the cycle after it
  always_comb begin
    state_n = state;
    done    = 1'b0;
    unique case (state)
      IDLE:  if (fall && !o_user_rx_valid) state_n = START;
      START: if (tick) state_n = s2 ? IDLE : DATA;
      DATA: begin
        if (tick && bit_cnt == LAST_D)
          state_n = (P_UART_CHECK != 0) ? CHECK : STOP;
      end
      CHECK: if (tick) state_n = STOP;
      STOP: begin
        if (tick && bit_cnt == LAST_S) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      if (state != state_n) bit_cnt <= '0;
      else if (tick)        bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && tick)
        shreg <= {s2, shreg[W-1:1]};

      if (state == IDLE)
        par_bit <= 1'b0;
      else if (state == CHECK && tick)
        par_bit <= s2;

      if (state == IDLE)
        ferr_acc <= 1'b0;
      else if (state == STOP && tick && !s2)
        ferr_acc <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_user_rx_data      <= '0;
      o_user_rx_valid     <= 1'b0;
      o_user_rx_check_err <= 1'b0;
      o_user_rx_frame_err <= 1'b0;
    end else begin
      o_user_rx_valid <= done;
      if (done) begin
        o_user_rx_data      <= shreg;
        o_user_rx_frame_err <= ferr_acc | ~s2;
        unique case (P_UART_CHECK)
          1:       o_user_rx_check_err <= ~ones_odd;
          2:       o_user_rx_check_err <= ones_odd;
          default: o_user_rx_check_err <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (8N1, 8E1, 8N2) fed by a frame driver;
// a queue-based scoreboard checks every delivered byte.
module tb_uart_rx;

  localparam int DIV = 10;

  typedef struct packed {
    logic [7:0] data;
    logic       cerr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;

  logic [7:0] dout [3];
  logic       vld  [3];
  logic       cerr [3];
  logic       ferr [3];

  exp_t q [3][$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat_start = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .P_SYSTEM_CLK(50_000_000), .P_UART_BUADRATE(5_000_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)
  ) u_n1 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[0]),
    .o_user_rx_data(dout[0]), .o_user_rx_valid(vld[0]),
    .o_user_rx_check_err(cerr[0]), .o_user_rx_frame_err(ferr[0])
  );

  uart_rx #(
    .P_SYSTEM_CLK(50_000_000), .P_UART_BUADRATE(5_000_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)
  ) u_e1 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[1]),
    .o_user_rx_data(dout[1]), .o_user_rx_valid(vld[1]),
    .o_user_rx_check_err(cerr[1]), .o_user_rx_frame_err(ferr[1])
  );

  uart_rx #(
    .P_SYSTEM_CLK(50_000_000), .P_UART_BUADRATE(5_000_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)
  ) u_n2 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx[2]),
    .o_user_rx_data(dout[2]), .o_user_rx_valid(vld[2]),
    .o_user_rx_check_err(cerr[2]), .o_user_rx_frame_err(ferr[2])
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // reference: what the receiver must report for a given line image
  function automatic exp_t model(input logic [7:0] d, input int pm,
                                 input logic p, input logic [1:0] st,
                                 input int ns);
    exp_t e;
    int ones;
    ones   = $countones(d) + int'(p);
    e.data = d;
    e.cerr = (pm == 1) ? (ones % 2 == 0) :
             (pm == 2) ? (ones % 2 == 1) : 1'b0;
    e.ferr = (st[0] == 1'b0) || (ns == 2 && st[1] == 1'b0);
    return e;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (vld[u]) begin
        if (q[u].size() == 0) begin
          check($sformatf("unexpected_valid_u%0d", u), 1, 0);
        end else begin
          exp_t e;
          e = q[u].pop_front();
          check($sformatf("data_u%0d", u), int'(dout[u]), int'(e.data));
          check($sformatf("cerr_u%0d", u), int'(cerr[u]), int'(e.cerr));
          check($sformatf("ferr_u%0d", u), int'(ferr[u]), int'(e.ferr));
          if (u == 0 && lat_start >= 0) begin
            check("latency_8n1", cyc - lat_start, 98);
            lat_start = -1;
          end
        end
      end
    end
  end

  task automatic idle(input int u, input int n);
    rx[u] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int u, input logic b);
    rx[u] = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic frame(input int u, input logic [7:0] d, input logic pflip,
                       input logic [1:0] st, input bit timed);
    int pm, ns;
    logic p;
    pm = (u == 1) ? 2 : 0;
    ns = (u == 2) ? 2 : 1;
    p  = ((pm == 1) ? ~^d : ^d) ^ pflip;
    q[u].push_back(model(d, pm, p, st, ns));
    if (timed) lat_start = cyc;
    drive_bit(u, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(u, d[i]);
    if (pm != 0) drive_bit(u, p);
    for (int j = 0; j < ns; j++) drive_bit(u, st[j]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, q[0].size() + q[1].size() + q[2].size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("rst_valid_u%0d", u), int'(vld[u]), 0);
      check($sformatf("rst_data_u%0d", u), int'(dout[u]), 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 with latency
    frame(0, 8'hA5, 1'b0, 2'b11, 1'b1);
    idle(0, 20);

    // even parity: good then flipped parity bit
    frame(1, 8'h03, 1'b0, 2'b11, 1'b0);
    idle(1, 5);
    frame(1, 8'h03, 1'b1, 2'b11, 1'b0);
    idle(1, 20);

    // glitch, then a real frame
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    idle(0, 30);
    frame(0, 8'h5A, 1'b0, 2'b11, 1'b0);
    idle(0, 20);

    // 8N2 with bad second stop, then break for 50 cycles
    frame(2, 8'hC7, 1'b0, 2'b01, 1'b0);
    repeat (50) @(negedge clk);
    idle(2, 20);
    frame(2, 8'h96, 1'b0, 2'b11, 1'b0);
    idle(2, 20);

    // back-to-back frames with no idle gap
    frame(0, 8'h00, 1'b0, 2'b11, 1'b0);
    frame(0, 8'hFF, 1'b0, 2'b11, 1'b0);
    frame(0, 8'h81, 1'b0, 2'b11, 1'b0);
    idle(0, 20);
    drain("drain_directed");

    // reset during data bit 4
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, i[0]);
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(vld[0]), 0);
    check("midrst_data", int'(dout[0]), 0);
    check("midrst_ferr", int'(ferr[0]), 0);
    idle(0, 120);
    rst = 1'b0;
    idle(0, 10);
    frame(0, 8'h3C, 1'b0, 2'b11, 1'b0);
    idle(0, 20);
    drain("drain_reset");

    // randomized frames on every configuration
    for (int k = 0; k < 60; k++) begin
      int u;
      logic [7:0] d;
      logic pf;
      logic [1:0] st;
      u  = $urandom_range(0, 2);
      d  = 8'($urandom);
      pf = (u == 1) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      st = 2'b11;
      if ($urandom_range(0, 4) == 0) st = 2'($urandom);
      if (u != 2) st[1] = 1'b1;
      frame(u, d, pf, st, 1'b0);
      if (st != 2'b11 || $urandom_range(0, 1) == 1)
        idle(u, $urandom_range(DIV, 3 * DIV));
      else
        idle(u, $urandom_range(0, 4));
    end
    idle(0, 30);
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
